guess_ctrl: RTL and testbench
=============================

Name: guess_ctrl

Overview:
- Sequential controller for the 2-bit comparator stage. It registers a secret value and a player's guesses, and drives the comparator's x and y operands.
- It consumes the comparator's not-equal and greater-or-equal outputs and turns them into too-high, too-low and win indicators.
- It counts attempts and locks the game after a fixed number of misses.
- Targets board switches/keys on the lab FPGA; the comparator itself stays purely combinational.

Parameters:
- MAX_TRIES, 3, number of guesses allowed before lockout; must be at least 1 and less than 2^TRY_W.
- TRY_W, 2, width of the attempt counter.

Ports:
- clk  in  1  system clock, rising-edge.
- resetn  in  1  asynchronous, active-low reset.
- sw_val  in  2  raw switch value, used both as secret and as guess.
- set_secret_req  in  1  raw key level (active-high); a rising edge loads sw_val as the secret.
- guess_req  in  1  raw key level (active-high); a rising edge loads sw_val as a guess.
- cmp_ne  in  1  comparator not-equal output (x != y).
- cmp_ge  in  1  comparator greater-or-equal output (x >= y).
- cmp_x  out  2  registered guess, drives comparator x1:x0.
- cmp_y  out  2  registered secret, drives comparator y1:y0.
- led_high  out  1  last guess > secret.
- led_low  out  1  last guess < secret.
- led_win  out  1  guess == secret.
- locked  out  1  MAX_TRIES misses used.
- tries  out  TRY_W  guesses taken since the last secret load.
- cmp_err  out  1  sticky; comparator returned an impossible code.

Behaviour:
- Reset (asynchronous, resetn low): all outputs 0, state NOSECRET, synchronizers cleared. Reset mid-game abandons the game immediately.
- Key inputs: each goes through a 2-flop synchronizer, then a rising-edge detect that makes a one-cycle pulse. Latency from raw edge to pulse is 2 clocks; the register load happens on the following edge.
- A held key produces exactly one pulse.
- State NOSECRET:
  - Secret pulse: cmp_y <= sw_val, tries <= 0, go to READY.
  - Guess pulse: ignored.
- State READY:
  - Guess pulse: cmp_x <= sw_val, tries <= tries+1, clear led_high/led_low, go to EVAL.
  - Secret pulse: reload the secret, tries <= 0, stay in READY.
- State EVAL (exactly 1 cycle): sample cmp_ne and cmp_ge, which are combinational on the registered cmp_x/cmp_y. Branches:
  - cmp_ne=0: led_win <= 1, go to WIN.
  - cmp_ne=1: led_high <= cmp_ge, led_low <= ~cmp_ge. If tries == MAX_TRIES, locked <= 1 and go to LOCKED; otherwise go to SHOW.
  - Invalid code (cmp_ne=0 with cmp_ge=0): cmp_err <= 1, then treated as a win.
  - Key pulses arriving during EVAL are discarded.
- State SHOW: hints are held.
  - Guess pulse: behaves as in READY.
  - Secret pulse: clears the hints, reloads the secret, tries <= 0, go to READY.
- States WIN and LOCKED: all outputs are held and guess pulses are ignored.
  - Secret pulse: clears led_win, locked and the hints, reloads the secret, tries <= 0, go to READY.
- Simultaneous pulses: a secret pulse and a guess pulse in the same cycle means the secret wins and the guess is dropped.
- Counter: tries never exceeds MAX_TRIES and never wraps.
- Output exclusivity: at most one of led_high, led_low and led_win is 1 at any time.
- cmp_err is cleared only by reset.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset, then a guess key with no secret loaded -> cmp_x=0, tries=0, no LEDs; the guess is ignored.
- Secret sw=2, then guess sw=3 -> led_high=1, tries=1. Guess sw=1 -> led_low=1, led_high=0, tries=2. Guess sw=2 -> led_win=1, tries=3, locked=0.
- Secret sw=0 (MAX_TRIES=3), guesses 1, 2, 3 -> after the third guess led_high=1, locked=1, tries=3. A fourth guess is ignored. A secret key then restarts with tries=0 and locked=0.
- Guess key held high for 20 cycles -> tries increments by exactly 1. Raw edge to cmp_x update takes 3 clocks.
- Secret key and guess key rising in the same cycle while in SHOW -> secret reloaded, tries=0, cmp_x unchanged, state READY.
- Bench forces cmp_ne=0 and cmp_ge=0 in EVAL -> cmp_err=1 and led_win=1. cmp_err survives a new secret load; resetn low mid-EVAL clears all outputs asynchronously.

Source files
------------

// File: rtl/guess_ctrl.sv
// Guessing-game controller: registers the secret and guesses for the external
// 2-bit comparator and turns its ne/ge outputs into hint, win and lockout state.
module guess_ctrl #(
   parameter int MAX_TRIES = 3,
   parameter int TRY_W     = 2
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [1:0]       sw_val,
   input  logic             set_secret_req,
   input  logic             guess_req,
   input  logic             cmp_ne,
   input  logic             cmp_ge,
   output logic [1:0]       cmp_x,
   output logic [1:0]       cmp_y,
   output logic             led_high,
   output logic             led_low,
   output logic             led_win,
   output logic             locked,
   output logic [TRY_W-1:0] tries,
   output logic             cmp_err
);

   localparam logic [2:0] S_NOSECRET = 3'd0;
   localparam logic [2:0] S_READY    = 3'd1;
   localparam logic [2:0] S_EVAL     = 3'd2;
   localparam logic [2:0] S_SHOW     = 3'd3;
   localparam logic [2:0] S_WIN      = 3'd4;
   localparam logic [2:0] S_LOCKED   = 3'd5;

   localparam logic [TRY_W-1:0] MAX_T = TRY_W'(MAX_TRIES);

   logic [2:0] state;
   logic [1:0] set_sync;
   logic [1:0] guess_sync;
   logic       set_prev;
   logic       guess_prev;
   logic       set_pulse;
   logic       guess_pulse;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         set_sync   <= '0;
         guess_sync <= '0;
         set_prev   <= 1'b0;
         guess_prev <= 1'b0;
      end else begin
         set_sync   <= {set_sync[0], set_secret_req};
         guess_sync <= {guess_sync[0], guess_req};
         set_prev   <= set_sync[1];
         guess_prev <= guess_sync[1];
      end
   end

   assign set_pulse   = set_sync[1] & ~set_prev;
   assign guess_pulse = guess_sync[1] & ~guess_prev;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= S_NOSECRET;
         cmp_x    <= '0;
         cmp_y    <= '0;
         led_high <= 1'b0;
         led_low  <= 1'b0;
         led_win  <= 1'b0;
         locked   <= 1'b0;
         tries    <= '0;
         cmp_err  <= 1'b0;
      end else begin
         case (state)
            S_NOSECRET: begin
               if (set_pulse) begin
                  cmp_y <= sw_val;
                  tries <= '0;
                  state <= S_READY;
               end
            end
            // Secret takes priority over a guess arriving in the same cycle.
            S_READY, S_SHOW: begin
               if (set_pulse) begin
                  cmp_y    <= sw_val;
                  tries    <= '0;
                  led_high <= 1'b0;
                  led_low  <= 1'b0;
                  state    <= S_READY;
               end else if (guess_pulse) begin
                  cmp_x    <= sw_val;
                  if (tries != MAX_T)
                     tries <= tries + 1'b1;
                  led_high <= 1'b0;
                  led_low  <= 1'b0;
                  state    <= S_EVAL;
               end
            end
            S_EVAL: begin
               if (!cmp_ne) begin
                  led_win <= 1'b1;
                  if (!cmp_ge)
                     cmp_err <= 1'b1;
                  state <= S_WIN;
               end else begin
                  led_high <= cmp_ge;
                  led_low  <= ~cmp_ge;
                  if (tries == MAX_T) begin
                     locked <= 1'b1;
                     state  <= S_LOCKED;
                  end else begin
                     state <= S_SHOW;
                  end
               end
            end
            S_WIN, S_LOCKED: begin
               if (set_pulse) begin
                  cmp_y    <= sw_val;
                  tries    <= '0;
                  led_high <= 1'b0;
                  led_low  <= 1'b0;
                  led_win  <= 1'b0;
                  locked   <= 1'b0;
                  state    <= S_READY;
               end
            end
            default: state <= S_NOSECRET;
         endcase
      end
   end

endmodule

// File: tb/tb_guess_ctrl.sv
// Directed bench for guess_ctrl with a behavioural 2-bit comparator that can
// be overridden to return the impossible (ne=0, ge=0) code.
module tb_guess_ctrl;

   logic       clk = 1'b0;
   logic       resetn;
   logic [1:0] sw_val;
   logic       set_secret_req;
   logic       guess_req;
   logic       cmp_ne;
   logic       cmp_ge;
   logic [1:0] cmp_x;
   logic [1:0] cmp_y;
   logic       led_high;
   logic       led_low;
   logic       led_win;
   logic       locked;
   logic [1:0] tries;
   logic       cmp_err;
   logic       force_bad;

   int unsigned n_pass = 0;
   int unsigned n_total = 0;

   guess_ctrl #(.MAX_TRIES(3), .TRY_W(2)) dut (
      .clk(clk), .resetn(resetn), .sw_val(sw_val),
      .set_secret_req(set_secret_req), .guess_req(guess_req),
      .cmp_ne(cmp_ne), .cmp_ge(cmp_ge), .cmp_x(cmp_x), .cmp_y(cmp_y),
      .led_high(led_high), .led_low(led_low), .led_win(led_win),
      .locked(locked), .tries(tries), .cmp_err(cmp_err)
   );

   always #5 clk = ~clk;

   always_comb begin
      cmp_ne = (cmp_x != cmp_y);
      cmp_ge = (cmp_x >= cmp_y);
      if (force_bad) begin
         cmp_ne = 1'b0;
         cmp_ge = 1'b0;
      end
   end

   // Packed view: {x, y, high, low, win, locked, tries, err}
   function automatic logic [10:0] st();
      return {cmp_x, cmp_y, led_high, led_low, led_win, locked, tries, cmp_err};
   endfunction

   function automatic logic [10:0] ev(input logic [1:0] x, input logic [1:0] y,
                                      input logic h, input logic l, input logic w,
                                      input logic lk, input logic [1:0] t, input logic e);
      return {x, y, h, l, w, lk, t, e};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press_guess(input logic [1:0] v);
      sw_val = v;
      guess_req = 1'b1;
      tick(4);
      guess_req = 1'b0;
      tick(3);
   endtask

   task automatic press_secret(input logic [1:0] v);
      sw_val = v;
      set_secret_req = 1'b1;
      tick(4);
      set_secret_req = 1'b0;
      tick(3);
   endtask

   task automatic test_reset();
      logic [10:0] e;
      resetn = 1'b0;
      tick(2);
      e = ev(2'd0, 2'd0, 0, 0, 0, 0, 2'd0, 0);
      n_total++;
      if (st() !== e) $display("FAIL reset_state: got %b want %b", st(), e);
      else n_pass++;
      resetn = 1'b1;
      tick(1);
      press_guess(2'd3);
      n_total++;
      if (st() !== e) $display("FAIL guess_without_secret: got %b want %b", st(), e);
      else n_pass++;
   endtask

   task automatic test_hints();
      logic [10:0] e;
      press_secret(2'd2);
      e = ev(2'd0, 2'd2, 0, 0, 0, 0, 2'd0, 0);
      n_total++;
      if (st() !== e) $display("FAIL secret_load: got %b want %b", st(), e);
      else n_pass++;
      press_guess(2'd3);
      e = ev(2'd3, 2'd2, 1, 0, 0, 0, 2'd1, 0);
      n_total++;
      if (st() !== e) $display("FAIL guess_high: got %b want %b", st(), e);
      else n_pass++;
      press_guess(2'd1);
      e = ev(2'd1, 2'd2, 0, 1, 0, 0, 2'd2, 0);
      n_total++;
      if (st() !== e) $display("FAIL guess_low: got %b want %b", st(), e);
      else n_pass++;
      press_guess(2'd2);
      e = ev(2'd2, 2'd2, 0, 0, 1, 0, 2'd3, 0);
      n_total++;
      if (st() !== e) $display("FAIL guess_win: got %b want %b", st(), e);
      else n_pass++;
      press_guess(2'd1);
      n_total++;
      if (st() !== e) $display("FAIL guess_after_win: got %b want %b", st(), e);
      else n_pass++;
   endtask

   task automatic test_lockout();
      logic [10:0] e;
      press_secret(2'd0);
      e = ev(2'd2, 2'd0, 0, 0, 0, 0, 2'd0, 0);
      n_total++;
      if (st() !== e) $display("FAIL restart_from_win: got %b want %b", st(), e);
      else n_pass++;
      press_guess(2'd1);
      e = ev(2'd1, 2'd0, 1, 0, 0, 0, 2'd1, 0);
      n_total++;
      if (st() !== e) $display("FAIL lock_miss1: got %b want %b", st(), e);
      else n_pass++;
      press_guess(2'd2);
      e = ev(2'd2, 2'd0, 1, 0, 0, 0, 2'd2, 0);
      n_total++;
      if (st() !== e) $display("FAIL lock_miss2: got %b want %b", st(), e);
      else n_pass++;
      press_guess(2'd3);
      e = ev(2'd3, 2'd0, 1, 0, 0, 1, 2'd3, 0);
      n_total++;
      if (st() !== e) $display("FAIL lock_miss3: got %b want %b", st(), e);
      else n_pass++;
      press_guess(2'd0);
      n_total++;
      if (st() !== e) $display("FAIL guess_when_locked: got %b want %b", st(), e);
      else n_pass++;
      press_secret(2'd1);
      e = ev(2'd3, 2'd1, 0, 0, 0, 0, 2'd0, 0);
      n_total++;
      if (st() !== e) $display("FAIL unlock_by_secret: got %b want %b", st(), e);
      else n_pass++;
   endtask

   task automatic test_held_key();
      logic [10:0] e;
      sw_val = 2'd2;
      guess_req = 1'b1;
      tick(2);
      n_total++;
      if (cmp_x !== 2'd3) $display("FAIL latency_early: got %0d want %0d", cmp_x, 3);
      else n_pass++;
      tick(1);
      e = ev(2'd2, 2'd1, 0, 0, 0, 0, 2'd1, 0);
      n_total++;
      if (st() !== e) $display("FAIL latency_load: got %b want %b", st(), e);
      else n_pass++;
      tick(17);
      e = ev(2'd2, 2'd1, 1, 0, 0, 0, 2'd1, 0);
      n_total++;
      if (st() !== e) $display("FAIL held_key: got %b want %b", st(), e);
      else n_pass++;
      guess_req = 1'b0;
      tick(3);
      n_total++;
      if (st() !== e) $display("FAIL held_key_release: got %b want %b", st(), e);
      else n_pass++;
   endtask

   task automatic test_simultaneous();
      logic [10:0] e;
      sw_val = 2'd3;
      set_secret_req = 1'b1;
      guess_req = 1'b1;
      tick(4);
      set_secret_req = 1'b0;
      guess_req = 1'b0;
      tick(3);
      e = ev(2'd2, 2'd3, 0, 0, 0, 0, 2'd0, 0);
      n_total++;
      if (st() !== e) $display("FAIL simultaneous_keys: got %b want %b", st(), e);
      else n_pass++;
      press_guess(2'd3);
      e = ev(2'd3, 2'd3, 0, 0, 1, 0, 2'd1, 0);
      n_total++;
      if (st() !== e) $display("FAIL ready_after_simul: got %b want %b", st(), e);
      else n_pass++;
   endtask

   task automatic test_bad_code();
      logic [10:0] e;
      press_secret(2'd0);
      e = ev(2'd3, 2'd0, 0, 0, 0, 0, 2'd0, 0);
      n_total++;
      if (st() !== e) $display("FAIL restart_before_bad: got %b want %b", st(), e);
      else n_pass++;
      force_bad = 1'b1;
      press_guess(2'd1);
      force_bad = 1'b0;
      e = ev(2'd1, 2'd0, 0, 0, 1, 0, 2'd1, 1);
      n_total++;
      if (st() !== e) $display("FAIL bad_code: got %b want %b", st(), e);
      else n_pass++;
      press_secret(2'd2);
      e = ev(2'd1, 2'd2, 0, 0, 0, 0, 2'd0, 1);
      n_total++;
      if (st() !== e) $display("FAIL err_sticky: got %b want %b", st(), e);
      else n_pass++;
      sw_val = 2'd3;
      guess_req = 1'b1;
      tick(3);
      e = ev(2'd3, 2'd2, 0, 0, 0, 0, 2'd1, 1);
      n_total++;
      if (st() !== e) $display("FAIL in_eval: got %b want %b", st(), e);
      else n_pass++;
      #2 resetn = 1'b0;
      #1;
      e = ev(2'd0, 2'd0, 0, 0, 0, 0, 2'd0, 0);
      n_total++;
      if (st() !== e) $display("FAIL async_reset: got %b want %b", st(), e);
      else n_pass++;
      guess_req = 1'b0;
      tick(2);
      resetn = 1'b1;
      tick(1);
      press_guess(2'd2);
      n_total++;
      if (st() !== e) $display("FAIL post_reset_guess: got %b want %b", st(), e);
      else n_pass++;
   endtask

   initial begin
      resetn = 1'b0;
      sw_val = 2'd0;
      set_secret_req = 1'b0;
      guess_req = 1'b0;
      force_bad = 1'b0;
      test_reset();
      test_hints();
      test_lockout();
      test_held_key();
      test_simultaneous();
      test_bad_code();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
